sm_product_accumulator: RTL and testbench

SM_PRODUCT_ACCUMULATOR -- requirements
Module: sm_product_accumulator

---
 rtl/sm_product_accumulator.sv | 108 ++++++++++
 tb/tb_sm_product_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_product_accumulator.sv
// Frame accumulator for sign-magnitude products with a saturating two's complement sum.
// A start loads the frame length, products are summed, and the result is held until the consumer accepts it.
module sm_product_accumulator #(
  parameter int ACC_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       count_i,
  input  logic [8:0]       product_i,
  input  logic             product_valid_i,
  output logic             product_ready_o,
  output logic [ACC_W-1:0] sum_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic             overflow_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       remaining_q, remaining_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sat_sum;
  logic             sat_hit;

  // One guard bit is enough: |acc| < 2^(ACC_W-1) and |product| <= 255 never overflow ACC_W+1 bits.
  always_comb begin
    mag_ext  = {{(ACC_W-7){1'b0}}, product_i[7:0]};
    prod_ext = product_i[8] ? (~mag_ext + {{ACC_W{1'b0}}, 1'b1}) : mag_ext;
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    sum_wide = acc_ext + prod_ext;
    sat_hit  = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
    if (!sat_hit) begin
      sat_sum = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      sat_sum = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sat_sum = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d       = '0;
          overflow_d  = 1'b0;
          remaining_d = (count_i == 4'd0) ? 5'd16 : {1'b0, count_i};
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (product_valid_i) begin
          acc_d       = sat_sum;
          overflow_d  = overflow_q | sat_hit;
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
    end
  end

  // The accumulator doubles as the result register; it only moves in ACCUM or on a new start.
  assign sum_o           = acc_q;
  assign overflow_o      = overflow_q;
  assign sum_valid_o     = (state_q == DONE);
  assign product_ready_o = (state_q == ACCUM);
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Scoreboard bench for sm_product_accumulator: 13-bit and 10-bit instances share one stimulus stream.
// A saturating integer model predicts each frame result; a monitor compares whenever sum_valid_o rises.
module tb_sm_product_accumulator;

  typedef logic [8:0] prod_t;
  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [3:0]  count_i;
  prod_t       product_i;
  logic        product_valid_i;
  logic        sum_ready_i;

  logic        ready_13, valid_13, ovf_13, busy_13;
  logic [12:0] sum_13;
  logic        ready_10, valid_10, ovf_10, busy_10;
  logic [9:0]  sum_10;

  int checks = 0;
  int errors = 0;

  exp_t q13[$];
  exp_t q10[$];
  int   m13, m10;
  bit   o13, o10;

  always #5 clk = ~clk;

  sm_product_accumulator #(.ACC_W(13)) dut13 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .count_i(count_i),
    .product_i(product_i), .product_valid_i(product_valid_i),
    .product_ready_o(ready_13), .sum_o(sum_13), .sum_valid_o(valid_13),
    .sum_ready_i(sum_ready_i), .overflow_o(ovf_13), .busy_o(busy_13)
  );

  sm_product_accumulator #(.ACC_W(10)) dut10 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .count_i(count_i),
    .product_i(product_i), .product_valid_i(product_valid_i),
    .product_ready_o(ready_10), .sum_o(sum_10), .sum_valid_o(valid_10),
    .sum_ready_i(sum_ready_i), .overflow_o(ovf_10), .busy_o(busy_10)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int clampAdd(input int acc, input int v, input int w, output bit hit);
    int hi, lo, s;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    s   = acc + v;
    hit = 1'b0;
    if (s > hi) begin s = hi; hit = 1'b1; end
    if (s < lo) begin s = lo; hit = 1'b1; end
    return s;
  endfunction

  function automatic void modelAdd(input prod_t p);
    int v;
    bit h;
    v   = p[8] ? -int'(p[7:0]) : int'(p[7:0]);
    m13 = clampAdd(m13, v, 13, h);
    o13 = o13 | h;
    m10 = clampAdd(m10, v, 10, h);
    o10 = o10 | h;
  endfunction

  task automatic applyStimulus(input logic [3:0] cnt, input prod_t prods[$], input int gaps[$]);
    start_i = 1'b1;
    count_i = cnt;
    @(posedge clk); #1;
    start_i = 1'b0;
    m13 = 0; m10 = 0; o13 = 1'b0; o10 = 1'b0;
    checkOutput("start_busy", int'(busy_13), 1);
    checkOutput("start_ready", int'(ready_10), 1);
    for (int i = 0; i < prods.size(); i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        product_valid_i = 1'b0;
        product_i = prod_t'($urandom);
        @(posedge clk); #1;
      end
      product_valid_i = 1'b1;
      product_i = prods[i];
      modelAdd(prods[i]);
      if (i == prods.size() - 1) begin
        q13.push_back('{sum: m13, ovf: int'(o13)});
        q10.push_back('{sum: m10, ovf: int'(o10)});
      end
      @(posedge clk); #1;
      product_valid_i = 1'b0;
    end
    checkOutput("latency_valid13", int'(valid_13), 1);
    checkOutput("latency_valid10", int'(valid_10), 1);
    checkOutput("done_ready", int'(ready_13), 0);
  endtask

  // Holds DONE for a while with stray start/product pulses, then hands the result off.
  task automatic releaseDone(input int hold, input bit start_on_exit);
    for (int c = 0; c < hold; c++) begin
      sum_ready_i = 1'b0;
      start_i = 1'(($urandom_range(0, 1)));
      product_valid_i = 1'(($urandom_range(0, 1)));
      product_i = prod_t'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", int'(valid_13), 1);
      checkOutput("hold_sum13", int'($signed(sum_13)), m13);
      checkOutput("hold_ovf10", int'(ovf_10), int'(o10));
    end
    start_i = start_on_exit;
    product_valid_i = 1'b0;
    sum_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    sum_ready_i = 1'b0;
    checkOutput("exit_valid", int'(valid_13), 0);
    checkOutput("exit_busy", int'(busy_10), 0);
    checkOutput("exit_sum13", int'($signed(sum_13)), m13);
    checkOutput("exit_sum10", int'($signed(sum_10)), m10);
    checkOutput("exit_ovf13", int'(ovf_13), int'(o13));
    checkOutput("exit_ovf10", int'(ovf_10), int'(o10));
    @(posedge clk); #1;
    checkOutput("idle_busy", int'(busy_13), 0);
  endtask

  // Monitor: every rising sum_valid_o consumes one scoreboard entry per instance.
  initial begin
    bit prev13 = 1'b0;
    bit prev10 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_13 && !prev13) begin
        if (q13.size() == 0) checkOutput("sb13_unexpected", 1, 0);
        else begin
          e = q13.pop_front();
          checkOutput("sb13_sum", int'($signed(sum_13)), e.sum);
          checkOutput("sb13_ovf", int'(ovf_13), e.ovf);
        end
      end
      if (valid_10 && !prev10) begin
        if (q10.size() == 0) checkOutput("sb10_unexpected", 1, 0);
        else begin
          e = q10.pop_front();
          checkOutput("sb10_sum", int'($signed(sum_10)), e.sum);
          checkOutput("sb10_ovf", int'(ovf_10), e.ovf);
        end
      end
      prev13 = valid_13;
      prev10 = valid_10;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prod_t p[$];
    int    gp[$];
    int    n;
    logic [3:0] cnt;

    rst_ni = 1'b0; start_i = 1'b0; count_i = '0; product_i = '0;
    product_valid_i = 1'b0; sum_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sum13", int'(sum_13), 0);
    checkOutput("rst_valid", int'(valid_13), 0);
    checkOutput("rst_busy", int'(busy_13), 0);
    checkOutput("rst_ready", int'(ready_13), 0);
    checkOutput("rst_ovf", int'(ovf_13), 0);
    rst_ni = 1'b1;

    // Three mixed products.
    p = {9'b0_11100001, 9'b1_00001111, 9'b0_00000000};
    gp = {0, 0, 0};
    applyStimulus(4'd3, p, gp);
    checkOutput("f1_sum13", int'($signed(sum_13)), 210);
    checkOutput("f1_ovf13", int'(ovf_13), 0);
    releaseDone(5, 1'b1);

    // Full 16-product frame: fits in 13 bits, saturates in 10 bits.
    p.delete(); gp.delete();
    for (int i = 0; i < 16; i++) begin p.push_back(9'b0_11100001); gp.push_back(0); end
    applyStimulus(4'd0, p, gp);
    checkOutput("f2_sum13", int'($signed(sum_13)), 3600);
    checkOutput("f2_ovf13", int'(ovf_13), 0);
    checkOutput("f2_sum10", int'($signed(sum_10)), 511);
    checkOutput("f2_ovf10", int'(ovf_10), 1);
    releaseDone(1, 1'b0);

    // Negative value followed by negative zero.
    p = {9'b1_11100001, 9'b1_00000000};
    gp = {0, 0};
    applyStimulus(4'd2, p, gp);
    checkOutput("f3_sum13", int'(sum_13), 'h1F1F);
    checkOutput("f3_ovf13", int'(ovf_13), 0);
    releaseDone(2, 1'b0);

    // Valid toggling 1,0,0,1.
    p = {9'd50, 9'b1_00000011};
    gp = {0, 2};
    applyStimulus(4'd2, p, gp);
    checkOutput("f4_sum13", int'($signed(sum_13)), 47);
    releaseDone(0, 1'b0);

    // Mid-frame reset, then stray products before any start.
    start_i = 1'b1; count_i = 4'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    product_valid_i = 1'b1; product_i = 9'd100;
    repeat (2) @(posedge clk);
    #1;
    product_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    checkOutput("mid_rst_sum13", int'(sum_13), 0);
    checkOutput("mid_rst_busy", int'(busy_13), 0);
    checkOutput("mid_rst_ready", int'(ready_13), 0);
    checkOutput("mid_rst_valid", int'(valid_13), 0);
    product_valid_i = 1'b1; product_i = 9'd5;
    repeat (2) @(posedge clk);
    #1;
    product_valid_i = 1'b0;
    checkOutput("post_rst_ready", int'(ready_13), 0);
    checkOutput("post_rst_sum13", int'(sum_13), 0);
    p = {9'd7};
    gp = {0};
    applyStimulus(4'd1, p, gp);
    checkOutput("f5_sum13", int'($signed(sum_13)), 7);
    releaseDone(1, 1'b0);

    // Randomized frames, biased toward large magnitudes to exercise both saturation bounds.
    for (int f = 0; f < 40; f++) begin
      cnt = 4'($urandom_range(0, 15));
      n = (cnt == 4'd0) ? 16 : int'(cnt);
      p.delete(); gp.delete();
      for (int i = 0; i < n; i++) begin
        p.push_back({1'($urandom_range(0, 1) & (f % 3 == 0 ? 1 : $urandom_range(0, 1))),
                     8'($urandom_range(0, 255))});
        if (f % 5 == 1) p[i][8] = 1'b1;
        gp.push_back(int'($urandom_range(0, 2)));
      end
      applyStimulus(cnt, p, gp);
      releaseDone(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    checkOutput("sb13_leftover", q13.size(), 0);
    checkOutput("sb10_leftover", q10.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
